// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder/subtractor.
// One operand pair is accepted in IDLE. The pair is then summed LSB-first
// through a single 1-bit full adder, one bit per cycle, over WIDTH cycles.
// The result is held in DONE until the consumer takes it.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             cout_q;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             last_bit;
  logic [1:0]       fa;

  // Single-bit full adder; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign fa       = full_add(a_q[idx], b_q[idx], c_q);
  assign last_bit = (idx == LAST_IDX);
  assign sum      = sum_q;
  assign cout     = cout_q;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture; B is stored inverted for subtraction (carry-in supplies the +1).
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  // Serial accumulation: one result bit and carry update per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      c_q    <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      c_q    <= sub;
      idx    <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= fa[0];
      c_q        <= fa[1];
      if (last_bit) cout_q <= fa[1];
      else          idx    <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and randomized checks of the serial adder
// against a cycle-level behavioural model of the handshake and arithmetic.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = computing, 2 = result offered.
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic [W:0]   m_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase = 1;
          m_cnt   = 0;
          if (sub) begin
            m_sum  = a - b;
            m_cout = (a >= b);
          end else begin
            m_tmp  = {1'b0, a} + {1'b0, b};
            m_sum  = m_tmp[W-1:0];
            m_cout = m_tmp[W];
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == W) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("model_sum", 32'(sum), 32'(m_sum));
        chk("model_cout", 32'(cout), 32'(m_cout));
      end
    end
  end

  // Issue one operation. Called at posedge+2 with the DUT idle.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                        input bit lit, input logic [W-1:0] es, input logic ec,
                        input int hold, input bit toggle);
    int n;
    bit got;
    logic [W-1:0] cap_s;
    logic cap_c;
    in_valid = 1'b1;
    a = oa;
    b = ob;
    sub = os;
    @(posedge clk);
    #2;
    in_valid = toggle;
    n = 0;
    got = 0;
    while (n < W + 4 && !got) begin
      @(negedge clk);
      n++;
      if (out_valid) got = 1;
      else if (toggle) begin
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        out_ready = 1'($urandom);
      end
    end
    if (!got) begin
      $display("FAIL timeout: out_valid never rose, expected latency %0d", W);
      $fatal(1, "timeout");
    end
    chk("latency", 32'(n - 1), 32'(W));
    if (lit) begin
      chk("lit_sum", 32'(sum), 32'(es));
      chk("lit_cout", 32'(cout), 32'(ec));
    end
    cap_s = sum;
    cap_c = cout;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (toggle) begin
        in_valid = ~in_valid;
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'(cap_s));
      chk("hold_cout", 32'(cout), 32'(cap_c));
      chk("hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'h0);
    chk("hs_in_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed, hand-computed results.
    run_op(8'h0F, 8'h01, 1'b0, 1, 8'h10, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 0, 0);
    run_op(8'h05, 8'h07, 1'b1, 1, 8'hFE, 1'b0, 0, 0);
    run_op(8'h20, 8'h20, 1'b1, 1, 8'h00, 1'b1, 1, 0);
    // Backpressure with inputs toggling, and in_valid held through RUN.
    run_op(8'h3C, 8'h5A, 1'b0, 1, 8'h96, 1'b0, 5, 1);
    run_op(8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, 2, 1);

    // Reset in the middle of RUN (bit index 4).
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    sub = 1'b0;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'h0);
    chk("midrst_cout", 32'(cout), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_op(8'h03, 8'h04, 1'b0, 1, 8'h07, 1'b0, 0, 0);

    // Randomized operations with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, '0, 1'b0,
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
